// File: rtl/sd_emmc_ddr_rx.sv
// sd_emmc_ddr_rx: eMMC DDR read-data receiver in the card clock domain.
// Finds the start bit, packs payload words, checks per-line CRC16 pairs and end bit.
module sd_emmc_ddr_rx #(
    parameter int BLK_W = 12,
    parameter int TO_W  = 24
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       iddr_Q1,
    input  logic [7:0]       iddr_Q2,
    input  logic             start,
    input  logic             abort,
    input  logic             bus_8bit,
    input  logic [BLK_W-1:0] block_size,
    input  logic [TO_W-1:0]  timeout,
    output logic [15:0]      rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             crc_err,
    output logic             end_err,
    output logic             timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_CRC,
        S_END,
        S_DONE
    } state_t;

    localparam logic [BLK_W-1:0] BLK_ONE = BLK_W'(1);
    localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);

    state_t           state;
    state_t           state_nx;

    logic             mode8;
    logic [BLK_W-1:0] bsize;
    logic [BLK_W-1:0] dcnt;
    logic [TO_W-1:0]  to_lim;
    logic [TO_W-1:0]  to_cnt;
    logic [3:0]       ccnt;
    logic [7:0]       lo_byte;
    logic [15:0]      crc_r [8];
    logic [15:0]      crc_f [8];

    logic [7:0]       act;
    logic             arm;
    logic             start_bit;
    logic             end_ok;
    logic             data_last;
    logic             to_hit;
    logic             crc_bad;
    logic [BLK_W-1:0] last_idx;
    logic [7:0]       bit_r;
    logic [7:0]       bit_f;

    // One serial step of x^16+x^12+x^5+1.
    function automatic logic [15:0] crc_step(input logic [15:0] c,
                                             input logic d);
        logic fb;
        fb = c[15] ^ d;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // Line qualification, phase-end conditions and CRC bit selection.
    always_comb begin
        act       = mode8 ? 8'hFF : 8'h0F;
        arm       = (state == S_IDLE) && start && !abort;
        start_bit = ((iddr_Q1 | iddr_Q2) & act) == 8'h00;
        end_ok    = ((iddr_Q1 & iddr_Q2) & act) == act;
        last_idx  = mode8 ? ({1'b0, bsize[BLK_W-1:1]} - BLK_ONE)
                          : (bsize - BLK_ONE);
        data_last = dcnt == last_idx;
        to_hit    = to_cnt == to_lim;
        bit_r     = 8'h00;
        bit_f     = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_r[i] = crc_r[i][~ccnt];
            bit_f[i] = crc_f[i][~ccnt];
        end
        crc_bad = (((iddr_Q1 ^ bit_r) | (iddr_Q2 ^ bit_f)) & act) != 8'h00;
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: if (start) state_nx = S_WAIT;
                S_WAIT: begin
                    if (start_bit)   state_nx = S_DATA;
                    else if (to_hit) state_nx = S_DONE;
                end
                S_DATA: if (data_last) state_nx = S_CRC;
                S_CRC:  if (ccnt == 4'd15) state_nx = S_END;
                S_END:  state_nx = S_DONE;
                S_DONE: state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Configuration capture and phase counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode8  <= 1'b0;
            bsize  <= '0;
            to_lim <= '0;
            to_cnt <= '0;
            dcnt   <= '0;
            ccnt   <= 4'd0;
        end else if (arm) begin
            mode8  <= bus_8bit;
            bsize  <= block_size;
            to_lim <= timeout;
            to_cnt <= '0;
            dcnt   <= '0;
            ccnt   <= 4'd0;
        end else begin
            if (state == S_WAIT) to_cnt <= to_cnt + TO_ONE;
            if (state == S_DATA) dcnt <= dcnt + BLK_ONE;
            if (state == S_CRC)  ccnt <= ccnt + 4'd1;
        end
    end

    // Per-line CRC engines: rising samples into crc_r, falling into crc_f.
    always_ff @(posedge clock) begin
        if (reset || arm) begin
            for (int i = 0; i < 8; i++) begin
                crc_r[i] <= 16'h0000;
                crc_f[i] <= 16'h0000;
            end
        end else if (state == S_DATA) begin
            for (int i = 0; i < 8; i++) begin
                crc_r[i] <= crc_step(crc_r[i], iddr_Q1[i]);
                crc_f[i] <= crc_step(crc_f[i], iddr_Q2[i]);
            end
        end
    end

    // Word assembly, status flags and the done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_data     <= 16'h0000;
            rx_valid    <= 1'b0;
            done        <= 1'b0;
            crc_err     <= 1'b0;
            end_err     <= 1'b0;
            timeout_err <= 1'b0;
            lo_byte     <= 8'h00;
        end else begin
            rx_valid <= 1'b0;
            done     <= state_nx == S_DONE;
            if (abort || arm) begin
                crc_err     <= 1'b0;
                end_err     <= 1'b0;
                timeout_err <= 1'b0;
            end else begin
                if (state == S_WAIT && !start_bit && to_hit)
                    timeout_err <= 1'b1;
                if (state == S_DATA) begin
                    if (mode8) begin
                        rx_data  <= {iddr_Q2, iddr_Q1};
                        rx_valid <= 1'b1;
                    end else if (dcnt[0]) begin
                        rx_data  <= {iddr_Q1[3:0], iddr_Q2[3:0], lo_byte};
                        rx_valid <= 1'b1;
                    end else begin
                        lo_byte  <= {iddr_Q1[3:0], iddr_Q2[3:0]};
                    end
                end
                if (state == S_CRC && crc_bad)
                    crc_err <= 1'b1;
                if (state == S_END && !end_ok)
                    end_err <= 1'b1;
            end
        end
    end

    assign busy = state != S_IDLE;

endmodule
